// File: rtl/mesh_edge_bridge.sv
// mesh_edge_bridge: host-side endpoint for one boundary port of a mesh node, with inject and eject FIFOs
module mesh_edge_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int TX_DEPTH   = 4,
   parameter int RX_DEPTH   = 4,
   parameter int CNT_WIDTH  = 16,
   parameter int DISCARD    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] host_tx_data,
   input  logic                  host_tx_valid,
   output logic                  host_tx_ready,
   output logic [DATA_WIDTH-1:0] host_rx_data,
   output logic                  host_rx_valid,
   input  logic                  host_rx_ready,
   output logic [DATA_WIDTH-1:0] node_din,
   output logic                  node_vin,
   input  logic                  node_rout,
   input  logic [DATA_WIDTH-1:0] node_dout,
   input  logic                  node_vout,
   output logic                  node_rin,
   input  logic                  clr_counts,
   output logic [CNT_WIDTH-1:0]  tx_count,
   output logic [CNT_WIDTH-1:0]  rx_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   logic [DATA_WIDTH-1:0] r_tx_mem [TX_DEPTH];
   logic [DATA_WIDTH-1:0] r_rx_mem [RX_DEPTH];
   logic [TAW:0]          r_tx_wp, r_tx_rp;
   logic [RAW:0]          r_rx_wp, r_rx_rp;
   logic [CNT_WIDTH-1:0]  r_tx_cnt, r_rx_cnt, r_drop_cnt;
   logic                  w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
   logic                  w_rx_full, w_rx_empty, w_rx_acc, w_rx_push, w_rx_drop, w_rx_pop;

   // Full/empty from the extra pointer MSB; handshakes derive only from registered state and peer inputs
   always_comb begin
      w_tx_full     = (r_tx_wp[TAW] != r_tx_rp[TAW]) && (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
      w_tx_empty    = r_tx_wp == r_tx_rp;
      w_rx_full     = (r_rx_wp[RAW] != r_rx_rp[RAW]) && (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
      w_rx_empty    = r_rx_wp == r_rx_rp;
      host_tx_ready = !w_tx_full;
      w_tx_push     = host_tx_valid && !w_tx_full;
      node_vin      = !w_tx_empty;
      node_din      = w_tx_empty ? '0 : r_tx_mem[r_tx_rp[TAW-1:0]];
      w_tx_pop      = !w_tx_empty && node_rout;
      node_rin      = (DISCARD != 0) ? 1'b1 : !w_rx_full;
      w_rx_acc      = node_vout && node_rin;
      w_rx_push     = w_rx_acc && !w_rx_full;
      w_rx_drop     = w_rx_acc && w_rx_full;
      host_rx_valid = !w_rx_empty;
      host_rx_data  = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[RAW-1:0]];
      w_rx_pop      = !w_rx_empty && host_rx_ready;
      tx_count      = r_tx_cnt;
      rx_count      = r_rx_cnt;
      drop_count    = r_drop_cnt;
   end

   // FIFO storage; contents need no reset since empty pointers hide them
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= host_tx_data;
      if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= node_dout;
   end

   // Pointer advance; reset discards everything buffered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_wp <= '0;
         r_tx_rp <= '0;
         r_rx_wp <= '0;
         r_rx_rp <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + (TAW+1)'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + (TAW+1)'(1);
         if (w_rx_push) r_rx_wp <= r_rx_wp + (RAW+1)'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + (RAW+1)'(1);
      end
   end

   // Saturating transfer counters; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || clr_counts) begin
         r_tx_cnt   <= '0;
         r_rx_cnt   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_tx_pop  && !(&r_tx_cnt))   r_tx_cnt   <= r_tx_cnt + CNT_WIDTH'(1);
         if (w_rx_acc  && !(&r_rx_cnt))   r_rx_cnt   <= r_rx_cnt + CNT_WIDTH'(1);
         if (w_rx_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
   end
endmodule
